// File: rtl/maxmin_reduce_ctrl_if.sv
// Operand/result stream bundle for the max-min reduction sequencer.
// master = job/operand source and result sink, slave = sequencer.
interface maxmin_reduce_ctrl_if #(
  parameter int W     = 16,
  parameter int LEN_W = 12
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic [W-1:0]     c_in;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [4*W-1:0]   in_a;
  logic [4*W-1:0]   in_b;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;

  modport master (
    output start, len, c_in, in_valid, in_a, in_b, out_ready,
    input  busy, in_ready, out_valid, out_data
  );

  modport slave (
    input  start, len, c_in, in_valid, in_a, in_b, out_ready,
    output busy, in_ready, out_valid, out_data
  );
endinterface

// File: rtl/maxmin_reduce_ctrl.sv
// Sequencer for one (min,max) dot product over 4-pair beats; optional post-cell
// pipeline register selected by MAXMIN_PIPE_EN (adds DRAIN state, 2-cycle result latency).
module maxmin_reduce_ctrl #(
  parameter int W     = 16,
  parameter int LEN_W = 12
) (
  input  logic                i_clk,
  input  logic                i_rst,
  maxmin_reduce_ctrl_if.slave bus
);

`ifdef MAXMIN_PIPE_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
`endif

  localparam logic [W-1:0] ONES = '1;

  function automatic logic [W-1:0] fmin(input logic [W-1:0] x, input logic [W-1:0] y);
    return (x < y) ? x : y;
  endfunction

  function automatic logic [W-1:0] fmax(input logic [W-1:0] x, input logic [W-1:0] y);
    return (x > y) ? x : y;
  endfunction

  state_t           r_state;
  logic [W-1:0]     r_acc;
  logic [LEN_W-1:0] r_beats_left;
  logic [1:0]       r_rem;
  logic             r_busy;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [W-1:0]     r_out_data;

  logic             w_last;
  logic             w_accept;
  logic [LEN_W-1:0] w_beats_init;
  logic [W-1:0]     w_ma [4];
  logic [W-1:0]     w_mb [4];
  logic [W-1:0]     w_part;

  assign w_last       = (r_beats_left == LEN_W'(1));
  assign w_accept     = bus.in_valid & r_in_ready;
  assign w_beats_init = (bus.len >> 2) + LEN_W'(|bus.len[1:0]);

  // Lanes past the job end on the final beat become the min identity.
  always_comb begin
    w_part = ONES;
    for (int i = 0; i < 4; i++) begin
      w_ma[i] = bus.in_a[i*W +: W];
      w_mb[i] = bus.in_b[i*W +: W];
      if (w_last && (r_rem != 2'd0) && (i >= int'(r_rem))) begin
        w_ma[i] = ONES;
        w_mb[i] = ONES;
      end
      w_part = fmin(w_part, fmax(w_ma[i], w_mb[i]));
    end
  end

`ifdef MAXMIN_PIPE_EN
  logic [W-1:0] r_p;
  logic         r_p_vld;
  logic [W-1:0] w_fold;
  assign w_fold = fmin(r_acc, r_p);
`else
  logic [W-1:0] w_cell;
  assign w_cell = fmin(r_acc, w_part);
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_acc        <= '0;
      r_beats_left <= '0;
      r_rem        <= '0;
      r_busy       <= 1'b0;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
`ifdef MAXMIN_PIPE_EN
      r_p          <= '0;
      r_p_vld      <= 1'b0;
`endif
    end else begin
`ifdef MAXMIN_PIPE_EN
      r_p_vld <= w_accept;
      if (w_accept) r_p   <= w_part;
      if (r_p_vld)  r_acc <= w_fold;
`endif
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_busy <= 1'b1;
            if (bus.len != '0) begin
              r_state      <= S_RUN;
              r_acc        <= bus.c_in;
              r_beats_left <= w_beats_init;
              r_rem        <= bus.len[1:0];
              r_in_ready   <= 1'b1;
            end else begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_out_data  <= bus.c_in;
            end
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_beats_left <= r_beats_left - LEN_W'(1);
`ifndef MAXMIN_PIPE_EN
            r_acc <= w_cell;
`endif
            if (w_last) begin
              r_in_ready <= 1'b0;
`ifdef MAXMIN_PIPE_EN
              r_state    <= S_DRAIN;
`else
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_out_data  <= w_cell;
`endif
            end
          end
        end
`ifdef MAXMIN_PIPE_EN
        // The final partial lands in r_p this cycle; fold it straight into the result.
        S_DRAIN: begin
          r_state     <= S_DONE;
          r_out_valid <= 1'b1;
          r_out_data  <= w_fold;
        end
`endif
        S_DONE: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;

endmodule
